// File: rtl/kl_mem_pkg.sv
// Shared types and sizing for the dual-port data memory.
package kl_mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [0:0] {S_CLEAR, S_READY} dm_state_t;

    typedef logic [ADDR_W-1:0] dm_addr_t;
    typedef logic [DATA_W-1:0] dm_word_t;

endpackage

// File: rtl/dm_read_port.sv
// One read port of dual_data_mem: write-first forwarding (p1 over p0) and
// the registered rdata output, held at zero while the memory is clearing.
module dm_read_port
    import kl_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic [DATA_W-1:0] mem_word,
    output logic [DATA_W-1:0] rdata
);

    dm_word_t rdata_d;
    dm_word_t rdata_q;

    // p1 is checked last so it overrides p0 when both hit this address.
    always_comb begin
        rdata_d = mem_word;
        if (w0_en && (w0_addr == rd_addr)) rdata_d = w0_data;
        if (w1_en && (w1_addr == rd_addr)) rdata_d = w1_data;
        if (!ready)                        rdata_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dual_data_mem.sv
// Shared 512x16 data memory for both pipelines with a post-reset zero-fill.
// Optional collision_cnt output is enabled by defining DM_COLLISION_CNT_EN.
module dual_data_mem
    import kl_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_DM_maddr,
    input  logic [DATA_W-1:0] p0_DM_wdata,
    input  logic              p0_DM_write_mem,
    output logic [DATA_W-1:0] p0_DM_rdata,
    input  logic [ADDR_W-1:0] p1_DM_maddr,
    input  logic [DATA_W-1:0] p1_DM_wdata,
    input  logic              p1_DM_write_mem,
    output logic [DATA_W-1:0] p1_DM_rdata,
    output logic              init_done
`ifdef DM_COLLISION_CNT_EN
    ,
    output logic [15:0]       collision_cnt
`endif
);

    dm_state_t         state_q, state_d;
    logic [ADDR_W-2:0] clr_cnt_q, clr_cnt_d;
    dm_word_t          mem [DEPTH];

    logic     ready;
    logic     w0_en, w1_en;
    dm_addr_t rd_addr [2];
    dm_word_t rd_data [2];

    assign ready = (state_q == S_READY);
    assign w0_en = ready && p0_DM_write_mem;
    assign w1_en = ready && p1_DM_write_mem;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = S_READY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clearing fills an even/odd word pair per cycle; p1 commits after p0 so it wins a tie.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[{clr_cnt_q, 1'b0}] <= '0;
            mem[{clr_cnt_q, 1'b1}] <= '0;
        end else begin
            if (w0_en) mem[p0_DM_maddr] <= p0_DM_wdata;
            if (w1_en) mem[p1_DM_maddr] <= p1_DM_wdata;
        end
    end

    assign rd_addr[0] = p0_DM_maddr;
    assign rd_addr[1] = p1_DM_maddr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            dm_read_port u_rd (
                .clk      (clk),
                .rst      (rst),
                .ready    (ready),
                .rd_addr  (rd_addr[gi]),
                .w0_en    (w0_en),
                .w0_addr  (p0_DM_maddr),
                .w0_data  (p0_DM_wdata),
                .w1_en    (w1_en),
                .w1_addr  (p1_DM_maddr),
                .w1_data  (p1_DM_wdata),
                .mem_word (mem[rd_addr[gi]]),
                .rdata    (rd_data[gi])
            );
        end
    endgenerate

    assign p0_DM_rdata = rd_data[0];
    assign p1_DM_rdata = rd_data[1];
    assign init_done   = ready;

`ifdef DM_COLLISION_CNT_EN
    logic [15:0] coll_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_cnt_q <= '0;
        end else if (w0_en && w1_en && (p0_DM_maddr == p1_DM_maddr)
                     && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign collision_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_dual_data_mem.sv
// Randomised self-checking bench for dual_data_mem against an array model.
module tb_dual_data_mem;
    import kl_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] p0_DM_maddr, p1_DM_maddr;
    logic [DATA_W-1:0] p0_DM_wdata, p1_DM_wdata;
    logic              p0_DM_write_mem, p1_DM_write_mem;
    logic [DATA_W-1:0] p0_DM_rdata, p1_DM_rdata;
    logic              init_done;
`ifdef DM_COLLISION_CNT_EN
    logic [15:0]       collision_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                coll_ref = 0;

    always #5 clk = ~clk;

    dual_data_mem dut (
        .clk             (clk),
        .rst             (rst),
        .p0_DM_maddr     (p0_DM_maddr),
        .p0_DM_wdata     (p0_DM_wdata),
        .p0_DM_write_mem (p0_DM_write_mem),
        .p0_DM_rdata     (p0_DM_rdata),
        .p1_DM_maddr     (p1_DM_maddr),
        .p1_DM_wdata     (p1_DM_wdata),
        .p1_DM_write_mem (p1_DM_write_mem),
        .p1_DM_rdata     (p1_DM_rdata),
        .init_done       (init_done)
`ifdef DM_COLLISION_CNT_EN
        ,
        .collision_cnt   (collision_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_DM_maddr = '0; p0_DM_wdata = '0; p0_DM_write_mem = 1'b0;
        p1_DM_maddr = '0; p1_DM_wdata = '0; p1_DM_write_mem = 1'b0;
    endtask

    // One ready-state access on both ports; called at a falling edge.
    task automatic txn(input logic [8:0] a0, input logic [15:0] d0, input logic w0,
                       input logic [8:0] a1, input logic [15:0] d1, input logic w1);
        logic [15:0] exp0, exp1;
        p0_DM_maddr = a0; p0_DM_wdata = d0; p0_DM_write_mem = w0;
        p1_DM_maddr = a1; p1_DM_wdata = d1; p1_DM_write_mem = w1;
        @(posedge clk);
        exp0 = ref_mem[a0];
        exp1 = ref_mem[a1];
        if (w0)              exp0 = d0;
        if (w0 && a0 == a1)  exp1 = d0;
        if (w1 && a1 == a0)  exp0 = d1;
        if (w1)              exp1 = d1;
        if (w0) ref_mem[a0] = d0;
        if (w1) ref_mem[a1] = d1;
        if (w0 && w1 && a0 == a1 && coll_ref < 65535) coll_ref++;
        #1;
        check("p0_rdata", 32'(p0_DM_rdata), 32'(exp0));
        check("p1_rdata", 32'(p1_DM_rdata), 32'(exp1));
        check("init_done", 32'(init_done), 32'd1);
`ifdef DM_COLLISION_CNT_EN
        check("coll_cnt", 32'(collision_cnt), 32'(coll_ref));
`endif
        $display("txn p0 a=%h d=%h w=%0b r=%h | p1 a=%h d=%h w=%0b r=%h",
                 a0, d0, w0, p0_DM_rdata, a1, d1, w1, p1_DM_rdata);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, checks the async effect, then runs the clear
    // while p0 tries to write 9'h003 (which must be ignored).
    task automatic reset_and_clear();
        int cnt;
        rst = 1'b0;
        #1;
        check("rst_p0_rdata", 32'(p0_DM_rdata), 32'd0);
        check("rst_p1_rdata", 32'(p1_DM_rdata), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
`ifdef DM_COLLISION_CNT_EN
        check("rst_coll_cnt", 32'(collision_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        p0_DM_maddr = 9'h003; p0_DM_wdata = 16'hFFFF; p0_DM_write_mem = 1'b1;
        cnt = 0;
        while (cnt < 600) begin
            @(posedge clk);
            #1;
            cnt++;
            if (init_done) break;
        end
        check("clear_len", 32'(cnt), 32'd256);
        check("clear_p0_rdata", 32'(p0_DM_rdata), 32'd0);
        $display("clear finished after %0d cycles", cnt);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        coll_ref = 0;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        logic [8:0]  ra0, ra1;
        idle_inputs();
        @(negedge clk);
        reset_and_clear();

        txn(9'h000, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        txn(9'h0FF, 16'h0, 1'b0, 9'h1FF, 16'h0, 1'b0);
        txn(9'h1FF, 16'h0, 1'b0, 9'h0FF, 16'h0, 1'b0);
        txn(9'h003, 16'h0, 1'b0, 9'h003, 16'h0, 1'b0);
        txn(9'h005, 16'hBEEF, 1'b1, 9'h000, 16'h0, 1'b0);
        txn(9'h000, 16'h0, 1'b0, 9'h005, 16'h0, 1'b0);
        txn(9'h01A, 16'h1111, 1'b1, 9'h01A, 16'h2222, 1'b1);
        txn(9'h01A, 16'h0, 1'b0, 9'h01A, 16'h0, 1'b0);
        txn(9'h007, 16'h0, 1'b0, 9'h007, 16'hCAFE, 1'b1);
        txn(9'h009, 16'hA5A5, 1'b1, 9'h009, 16'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if (n[0]) begin
                ra0 = 9'($urandom_range(0, 15));
                ra1 = 9'($urandom_range(0, 15));
            end else begin
                ra0 = 9'($urandom_range(0, DEPTH - 1));
                ra1 = 9'($urandom_range(0, DEPTH - 1));
            end
            txn(ra0, 16'($urandom), 1'($urandom), ra1, 16'($urandom), 1'($urandom));
        end

        txn(9'h100, 16'h1234, 1'b1, 9'h000, 16'h0, 1'b0);
        reset_and_clear();
        txn(9'h100, 16'h0, 1'b0, 9'h100, 16'h0, 1'b0);
        txn(9'h005, 16'h0, 1'b0, 9'h01A, 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
